// File: rtl/regbank.sv
// Register-bus responder: RW control registers, RO status pass-through and a
// sticky clear-on-read event byte, decoded from a shared 8-bit address/data bus.
module regbank #(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         NCTRL      = 4,
  parameter int         NSTATUS    = 2,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             address,
  inout  wire  [7:0]                             data,
  input  logic                                   rd,
  input  logic                                   wr,
  output logic [8*NCTRL-1:0]                     ctrl_out,
  output logic [NCTRL-1:0]                       ctrl_wr,
  input  logic [8*((NSTATUS > 0) ? NSTATUS : 1)-1:0] status_in,
  input  logic [7:0]                             event_in,
  output logic                                   event_pending
);

  localparam logic [7:0] NC     = 8'(NCTRL);
  localparam logic [7:0] NS     = 8'(NSTATUS);
  localparam logic [7:0] EV_OFF = NC + NS;
  localparam logic [7:0] NBANK  = EV_OFF + 8'd1;

  logic [8:0] diff;
  logic [7:0] offset;
  logic       hit;
  logic       ev_rd;
  logic       wr_ok;
  logic [7:0] ctrl_q [NCTRL];
  logic [7:0] ev_q;
  logic [7:0] ev_next;
  logic [7:0] rdata;

  // A borrow out of the 9-bit subtraction means the address lies below the bank.
  assign diff   = {1'b0, address} - {1'b0, BASE_ADDR};
  assign offset = diff[7:0];
  assign hit    = !diff[8] && (offset < NBANK);
  assign ev_rd  = rd && hit && (offset == EV_OFF) && !reset;
  assign wr_ok  = wr && hit && !rd && !reset;

  // Bits arriving during a clearing read survive and show up on the next read.
  assign ev_next = (ev_q & ~(ev_rd ? ev_q : 8'h00)) | event_in;

  always_comb begin
    rdata = ev_q;
    for (int i = 0; i < NCTRL; i++) begin
      if (offset == 8'(i)) rdata = ctrl_q[i];
    end
    for (int j = 0; j < NSTATUS; j++) begin
      if (offset == NC + 8'(j)) rdata = status_in[8*j +: 8];
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NCTRL; i++) begin
      ctrl_out[8*i +: 8] = ctrl_q[i];
    end
  end

  assign data = (rd && hit && !reset) ? rdata : 8'hzz;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCTRL; i++) ctrl_q[i] <= CTRL_RESET;
      ctrl_wr       <= '0;
      ev_q          <= 8'h00;
      event_pending <= 1'b0;
    end else begin
      ctrl_wr <= '0;
      for (int i = 0; i < NCTRL; i++) begin
        if (wr_ok && (offset == 8'(i))) begin
          ctrl_q[i]  <= data;
          ctrl_wr[i] <= 1'b1;
        end
      end
      ev_q          <= ev_next;
      event_pending <= |ev_next;
    end
  end

endmodule

// File: tb/tb_regbank.sv
// Scoreboard bench for regbank: stimulus queues expected values tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_regbank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [7:0]  drv;
  logic        rd;
  logic        wr;
  logic [31:0] ctrl_out;
  logic [3:0]  ctrl_wr;
  logic [15:0] status_in;
  logic [7:0]  event_in;
  logic        event_pending;
  wire  [7:0]  data;

  always #5 clk = ~clk;

  // Initiator drives the bus whenever it is not reading; pullups expose an idle bus.
  assign data = rd ? 8'hzz : drv;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  regbank #(
    .BASE_ADDR (8'h10),
    .NCTRL     (4),
    .NSTATUS   (2),
    .CTRL_RESET(8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data         (data),
    .rd           (rd),
    .wr           (wr),
    .ctrl_out     (ctrl_out),
    .ctrl_wr      (ctrl_wr),
    .status_in    (status_in),
    .event_in     (event_in),
    .event_pending(event_pending)
  );

  localparam int K_DATA = 0, K_CTRL = 1, K_STRB = 2, K_PEND = 3;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  chk_t        mc;
  logic [31:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mc = sb.pop_front();
      case (mc.kind)
        K_DATA:  act = {24'h0, data};
        K_CTRL:  act = ctrl_out;
        K_STRB:  act = {28'h0, ctrl_wr};
        default: act = {31'h0, event_pending};
      endcase
      total++;
      if (mc.due != cyc || act !== mc.exp)
        $display("FAIL %s: got %h want %h (cycle %0d due %0d)", mc.name, act, mc.exp, cyc, mc.due);
      else
        passed++;
    end
  end

  task automatic expect_at(input int due, input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic drive(input logic rst, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d, input logic [7:0] ev);
    @(posedge clk);
    #1;
    reset    = rst;
    rd       = r;
    wr       = w;
    address  = a;
    drv      = d;
    event_in = ev;
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    drive(1'b0, 1'b1, 1'b0, a, 8'h00, 8'h00);
    expect_at(cyc, K_DATA, {24'h0, exp}, name);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d, 8'h00);
  endtask

  task automatic idle(input logic [7:0] ev);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ev);
  endtask

  initial begin
    reset     = 1'b1;
    rd        = 1'b0;
    wr        = 1'b0;
    address   = 8'h00;
    drv       = 8'h00;
    event_in  = 8'h00;
    status_in = 16'h3C81;

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 8'h00);
    expect_at(cyc + 1, K_CTRL, 32'h0, "rst_wr_ctrl");
    expect_at(cyc + 1, K_STRB, 32'h0, "rst_wr_strobe");
    drive(1'b1, 1'b1, 1'b0, 8'h16, 8'h00, 8'h01);
    expect_at(cyc, K_DATA, 32'hFF, "rst_rd_z");
    expect_at(cyc + 1, K_PEND, 32'h0, "rst_ev_ignored");

    for (int i = 0; i < 4; i++) do_rd(8'h10 + 8'(i), 8'h00, "rd_ctrl_reset");
    expect_at(cyc, K_CTRL, 32'h0, "ctrl_reset");
    expect_at(cyc, K_PEND, 32'h0, "pend_reset");

    do_wr(8'h12, 8'hA5);
    expect_at(cyc + 1, K_CTRL, 32'h00A50000, "wr12_ctrl");
    expect_at(cyc + 1, K_STRB, 32'h4, "wr12_strobe");
    idle(8'h00);
    expect_at(cyc + 1, K_STRB, 32'h0, "wr12_strobe_end");
    do_rd(8'h12, 8'hA5, "rd12");

    do_rd(8'h14, 8'h81, "rd_status0");
    do_rd(8'h15, 8'h3C, "rd_status1");
    do_wr(8'h14, 8'hFF);
    expect_at(cyc + 1, K_STRB, 32'h0, "wr_status_strobe");
    expect_at(cyc + 1, K_CTRL, 32'h00A50000, "wr_status_ctrl");
    do_rd(8'h14, 8'h81, "rd_status0_again");

    idle(8'h05);
    expect_at(cyc + 1, K_PEND, 32'h1, "ev_pending_set");
    drive(1'b0, 1'b1, 1'b0, 8'h16, 8'h00, 8'h80);
    expect_at(cyc, K_DATA, 32'h05, "ev_rd_first");
    do_rd(8'h16, 8'h80, "ev_rd_late_bit");
    expect_at(cyc, K_PEND, 32'h1, "ev_pending_late");
    do_rd(8'h16, 8'h00, "ev_rd_empty");
    expect_at(cyc + 1, K_PEND, 32'h0, "ev_pending_clear");

    foreach (sb[i]) begin end
    do_rd(8'h0F, 8'hFF, "miss_rd_0f");
    do_wr(8'h0F, 8'h11);
    expect_at(cyc + 1, K_STRB, 32'h0, "miss_wr_0f_strobe");
    do_rd(8'h17, 8'hFF, "miss_rd_17");
    do_wr(8'h17, 8'h11);
    expect_at(cyc + 1, K_STRB, 32'h0, "miss_wr_17_strobe");
    do_rd(8'hFF, 8'hFF, "miss_rd_ff");
    do_wr(8'hFF, 8'h11);
    expect_at(cyc + 1, K_STRB, 32'h0, "miss_wr_ff_strobe");
    expect_at(cyc + 1, K_CTRL, 32'h00A50000, "miss_ctrl");

    drive(1'b0, 1'b1, 1'b1, 8'h11, 8'h77, 8'h00);
    expect_at(cyc, K_DATA, 32'h00, "rdwr_old_value");
    expect_at(cyc + 1, K_STRB, 32'h0, "rdwr_strobe");
    expect_at(cyc + 1, K_CTRL, 32'h00A50000, "rdwr_ctrl");

    do_wr(8'h10, 8'h11);
    expect_at(cyc + 1, K_STRB, 32'h1, "b2b_strobe0");
    do_wr(8'h13, 8'h33);
    expect_at(cyc + 1, K_STRB, 32'h8, "b2b_strobe3");
    expect_at(cyc + 1, K_CTRL, 32'h33A50011, "b2b_ctrl");

    idle(8'hFF);
    expect_at(cyc + 1, K_PEND, 32'h1, "ev_before_reset");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    expect_at(cyc + 1, K_PEND, 32'h0, "ev_after_reset");
    expect_at(cyc + 1, K_CTRL, 32'h0, "ctrl_after_reset");
    idle(8'h00);
    do_rd(8'h16, 8'h00, "ev_rd_after_reset");
    idle(8'h00);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      total++;
      $display("FAIL %s: never checked, want %h", mc.name, mc.exp);
    end

    @(negedge clk);
    total++;
    if (ctrl_out !== 32'h0)
      $display("FAIL final_ctrl: got %h want %h", ctrl_out, 32'h0);
    else
      passed++;
    total++;
    if (ctrl_wr !== 4'h0)
      $display("FAIL final_strobe: got %h want %h", ctrl_wr, 4'h0);
    else
      passed++;
    total++;
    if (event_pending !== 1'b0)
      $display("FAIL final_pending: got %b want 0", event_pending);
    else
      passed++;
    total++;
    if (data !== 8'h00)
      $display("FAIL final_bus_idle: got %h want %h", data, 8'h00);
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
